// File: rtl/operand_fetch_pkg.sv
// rtl/operand_fetch_pkg.sv - shared core constants for the operand-fetch stage
package operand_fetch_pkg;

  localparam int REG_BUS_W      = 32;
  localparam int REG_ADDR_BUS_W = 5;
  localparam int REG_NUM_DEF    = 32;
  localparam int REG_NUM_LOG2   = 5;
  localparam int PAYLOAD_W_DEF  = 64;

  localparam logic [REG_BUS_W-1:0] ZERO_WORD    = '0;
  localparam logic                 READ_ENABLE  = 1'b1;
  localparam logic                 WRITE_ENABLE = 1'b1;
  localparam logic                 RST_ENABLE_N = 1'b0;

endpackage

// File: rtl/reg_busy_table.sv
// rtl/reg_busy_table.sv - per-register busy bits with set/clear ports and clear-bypassed lookups
module reg_busy_table
  import operand_fetch_pkg::*;
#(
  parameter int REG_NUM    = REG_NUM_DEF,
  parameter int REG_ADDR_W = REG_ADDR_BUS_W
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  flush,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_idx,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_idx,
  input  logic [REG_ADDR_W-1:0] look_a_idx,
  input  logic [REG_ADDR_W-1:0] look_b_idx,
  input  logic [REG_ADDR_W-1:0] look_c_idx,
  output logic                  busy_a,
  output logic                  busy_b,
  output logic                  busy_c
);

  logic [REG_NUM-1:0] busy_q;
  logic [REG_NUM-1:0] busy_d;

  // A set in the same cycle as a clear of the same index wins.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_idx] = 1'b0;
    if (set_en) busy_d[set_idx] = 1'b1;
    busy_d[0] = 1'b0;
    if (flush) busy_d = '0;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (rst_in == RST_ENABLE_N) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // A writeback landing this cycle already releases its register.
  function automatic logic lookup(input logic [REG_ADDR_W-1:0] idx);
    return busy_q[idx] & ~(clr_en & (clr_idx == idx));
  endfunction

  assign busy_a = lookup(look_a_idx);
  assign busy_b = lookup(look_b_idx);
  assign busy_c = lookup(look_c_idx);

endmodule

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - decode-to-execute operand fetch with hold/issue slots and busy-bit scoreboard
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int XLEN       = REG_BUS_W,
  parameter int REG_NUM    = REG_NUM_DEF,
  parameter int REG_ADDR_W = REG_ADDR_BUS_W,
  parameter int PAYLOAD_W  = PAYLOAD_W_DEF
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  flush,
  input  logic                  dec_valid,
  output logic                  dec_ready,
  input  logic [REG_ADDR_W-1:0] dec_rs1,
  input  logic [REG_ADDR_W-1:0] dec_rs2,
  input  logic                  dec_rs1_en,
  input  logic                  dec_rs2_en,
  input  logic [REG_ADDR_W-1:0] dec_rd,
  input  logic                  dec_rd_en,
  input  logic [PAYLOAD_W-1:0]  dec_payload,
  output logic                  re1,
  output logic                  re2,
  output logic [REG_ADDR_W-1:0] raddr1,
  output logic [REG_ADDR_W-1:0] raddr2,
  input  logic [XLEN-1:0]       rdata1,
  input  logic [XLEN-1:0]       rdata2,
  output logic                  we,
  output logic [REG_ADDR_W-1:0] waddr,
  output logic [XLEN-1:0]       wdata,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  output logic                  iss_valid,
  input  logic                  iss_ready,
  output logic [XLEN-1:0]       iss_op1,
  output logic [XLEN-1:0]       iss_op2,
  output logic [REG_ADDR_W-1:0] iss_rd,
  output logic                  iss_rd_en,
  output logic [PAYLOAD_W-1:0]  iss_payload
);

  logic                  hold_valid;
  logic [REG_ADDR_W-1:0] hold_rs1, hold_rs2, hold_rd;
  logic                  hold_rs1_en, hold_rs2_en, hold_rd_en;
  logic [PAYLOAD_W-1:0]  hold_payload;

  logic busy_rs1, busy_rs2, busy_rd;
  logic haz1, haz2, haz_waw;
  logic out_free, advance, accept;

  assign we    = wb_valid;
  assign waddr = wb_rd;
  assign wdata = wb_data;

  assign re1    = hold_valid & hold_rs1_en;
  assign re2    = hold_valid & hold_rs2_en;
  assign raddr1 = hold_rs1;
  assign raddr2 = hold_rs2;

  reg_busy_table #(
    .REG_NUM    (REG_NUM),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_busy (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .flush      (flush),
    .set_en     (advance & hold_rd_en),
    .set_idx    (hold_rd),
    .clr_en     (wb_valid),
    .clr_idx    (wb_rd),
    .look_a_idx (hold_rs1),
    .look_b_idx (hold_rs2),
    .look_c_idx (hold_rd),
    .busy_a     (busy_rs1),
    .busy_b     (busy_rs2),
    .busy_c     (busy_rd)
  );

  assign haz1     = hold_rs1_en & (hold_rs1 != '0) & busy_rs1;
  assign haz2     = hold_rs2_en & (hold_rs2 != '0) & busy_rs2;
  assign haz_waw  = hold_rd_en & (hold_rd != '0) & busy_rd;
  assign out_free = ~iss_valid | iss_ready;
  assign advance  = hold_valid & ~(haz1 | haz2 | haz_waw) & out_free & ~flush;
  assign dec_ready = ~flush & (~hold_valid | advance);
  assign accept    = dec_valid & dec_ready;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (rst_in == RST_ENABLE_N) begin
      hold_valid   <= 1'b0;
      hold_rs1     <= '0;
      hold_rs2     <= '0;
      hold_rd      <= '0;
      hold_rs1_en  <= 1'b0;
      hold_rs2_en  <= 1'b0;
      hold_rd_en   <= 1'b0;
      hold_payload <= '0;
    end else if (flush) begin
      hold_valid <= 1'b0;
    end else if (accept) begin
      hold_valid   <= 1'b1;
      hold_rs1     <= dec_rs1;
      hold_rs2     <= dec_rs2;
      hold_rd      <= dec_rd;
      hold_rs1_en  <= dec_rs1_en;
      hold_rs2_en  <= dec_rs2_en;
      hold_rd_en   <= dec_rd_en;
      hold_payload <= dec_payload;
    end else if (advance) begin
      hold_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (rst_in == RST_ENABLE_N) begin
      iss_valid   <= 1'b0;
      iss_op1     <= '0;
      iss_op2     <= '0;
      iss_rd      <= '0;
      iss_rd_en   <= 1'b0;
      iss_payload <= '0;
    end else if (flush) begin
      iss_valid <= 1'b0;
    end else if (advance) begin
      iss_valid   <= 1'b1;
      iss_op1     <= hold_rs1_en ? rdata1 : '0;
      iss_op2     <= hold_rs2_en ? rdata2 : '0;
      iss_rd      <= hold_rd;
      iss_rd_en   <= hold_rd_en;
      iss_payload <= hold_payload;
    end else if (iss_ready) begin
      iss_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - directed self-checking bench for operand_fetch
module tb_operand_fetch;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        flush;
  logic        dec_valid, dec_ready;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic        dec_rs1_en, dec_rs2_en, dec_rd_en;
  logic [63:0] dec_payload;
  logic        re1, re2;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        iss_valid, iss_ready;
  logic [31:0] iss_op1, iss_op2;
  logic [4:0]  iss_rd;
  logic        iss_rd_en;
  logic [63:0] iss_payload;

  logic [31:0] rf [32];
  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  // Register file model with same-cycle write bypass.
  always @(posedge clk_in) if (we && waddr != 5'd0) rf[waddr] <= wdata;
  assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : ((we && waddr == raddr1) ? wdata : rf[raddr1]);
  assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : ((we && waddr == raddr2) ? wdata : rf[raddr2]);

  operand_fetch dut (
    .clk_in(clk_in), .rst_in(rst_in), .flush(flush),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rs1_en(dec_rs1_en), .dec_rs2_en(dec_rs2_en),
    .dec_rd(dec_rd), .dec_rd_en(dec_rd_en), .dec_payload(dec_payload),
    .re1(re1), .re2(re2), .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .we(we), .waddr(waddr), .wdata(wdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op1(iss_op1), .iss_op2(iss_op2),
    .iss_rd(iss_rd), .iss_rd_en(iss_rd_en), .iss_payload(iss_payload)
  );

  task automatic clk1();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wb_write(input logic [4:0] r, input logic [31:0] d);
    wb_valid = 1'b1; wb_rd = r; wb_data = d;
    clk1();
    wb_valid = 1'b0;
  endtask

  task automatic offer(input logic [4:0] rs1, input logic e1, input logic [4:0] rs2, input logic e2,
                       input logic [4:0] rd, input logic rde, input logic [63:0] pl);
    int n = 0;
    dec_rs1 = rs1; dec_rs1_en = e1; dec_rs2 = rs2; dec_rs2_en = e2;
    dec_rd = rd; dec_rd_en = rde; dec_payload = pl; dec_valid = 1'b1;
    #1;
    while (!dec_ready && n < 20) begin clk1(); n++; end
    if (!dec_ready) begin
      checks++; errors++;
      $display("FAIL offer_timeout: dec_ready=%b after %0d cycles, want 1", dec_ready, n);
    end
    clk1();
    dec_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    clk1(); clk1();
    checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL reset_iss_valid: got %b want 0", iss_valid); end
    checks++; if (iss_op1 !== 32'd0 || iss_rd_en !== 1'b0 || iss_payload !== 64'd0) begin errors++;
      $display("FAIL reset_iss_fields: op1=%h rd_en=%b pl=%h want 0", iss_op1, iss_rd_en, iss_payload); end
    checks++; if (dut.u_busy.busy_q !== 32'd0) begin errors++; $display("FAIL reset_busy: got %h want 0", dut.u_busy.busy_q); end
    rst_in = 1'b1;
    clk1();
    checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL reset_dec_ready: got %b want 1", dec_ready); end
  endtask

  task automatic test_single();
    offer(5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 64'hA5A5_0000_1234_5678);
    checks++; if (re1 !== 1'b1 || raddr1 !== 5'd1 || re2 !== 1'b1 || raddr2 !== 5'd2) begin errors++;
      $display("FAIL single_read_ports: re1=%b a1=%0d re2=%b a2=%0d want 1/1/1/2", re1, raddr1, re2, raddr2); end
    checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL single_not_early: iss_valid=%b want 0", iss_valid); end
    clk1();
    checks++; if (iss_valid !== 1'b1 || iss_op1 !== 32'd5 || iss_op2 !== 32'd7) begin errors++;
      $display("FAIL single_issue: v=%b op1=%h op2=%h want 1/5/7", iss_valid, iss_op1, iss_op2); end
    checks++; if (iss_rd !== 5'd3 || iss_rd_en !== 1'b1 || iss_payload !== 64'hA5A5_0000_1234_5678) begin errors++;
      $display("FAIL single_fields: rd=%0d en=%b pl=%h want 3/1/a5a5000012345678", iss_rd, iss_rd_en, iss_payload); end
    checks++; if (dut.u_busy.busy_q[3] !== 1'b1) begin errors++; $display("FAIL single_busy3: got %b want 1", dut.u_busy.busy_q[3]); end
    clk1();
    checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL single_drain: iss_valid=%b want 0", iss_valid); end
  endtask

  task automatic test_raw();
    wb_write(5'd3, 32'h33);
    offer(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 64'h1);
    offer(5'd3, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 64'h2);
    for (int i = 0; i < 3; i++) begin
      checks++; if (dec_ready !== 1'b0) begin errors++; $display("FAIL raw_stall_ready[%0d]: got %b want 0", i, dec_ready); end
      if (i < 2) clk1();
    end
    checks++; if (dut.u_busy.busy_q[3] !== 1'b1) begin errors++; $display("FAIL raw_busy3: got %b want 1", dut.u_busy.busy_q[3]); end
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h11;
    #1;
    checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL raw_wb_advance: dec_ready=%b want 1", dec_ready); end
    clk1();
    wb_valid = 1'b0;
    checks++; if (iss_valid !== 1'b1 || iss_op1 !== 32'h11 || iss_op2 !== 32'd0 || iss_rd !== 5'd6) begin errors++;
      $display("FAIL raw_issue: v=%b op1=%h op2=%h rd=%0d want 1/11/0/6", iss_valid, iss_op1, iss_op2, iss_rd); end
    checks++; if (dut.u_busy.busy_q[3] !== 1'b0 || dut.u_busy.busy_q[6] !== 1'b1) begin errors++;
      $display("FAIL raw_busy: b3=%b b6=%b want 0/1", dut.u_busy.busy_q[3], dut.u_busy.busy_q[6]); end
    wb_write(5'd6, 32'h66);
  endtask

  task automatic test_waw();
    offer(5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 64'h3);
    offer(5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 64'h4);
    checks++; if (dec_ready !== 1'b0) begin errors++; $display("FAIL waw_stall: dec_ready=%b want 0", dec_ready); end
    wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 32'h44;
    #1;
    checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL waw_advance: dec_ready=%b want 1", dec_ready); end
    clk1();
    wb_valid = 1'b0;
    checks++; if (dut.u_busy.busy_q[4] !== 1'b1) begin errors++; $display("FAIL waw_set_wins: busy4=%b want 1", dut.u_busy.busy_q[4]); end
    checks++; if (iss_valid !== 1'b1 || iss_payload !== 64'h4) begin errors++;
      $display("FAIL waw_issue: v=%b pl=%h want 1/4", iss_valid, iss_payload); end
    wb_write(5'd4, 32'h44);
  endtask

  task automatic test_zero_reg();
    offer(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 64'h5);
    offer(5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 64'h6);
    checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL zero_no_stall: dec_ready=%b want 1", dec_ready); end
    clk1();
    checks++; if (iss_valid !== 1'b1 || iss_op1 !== 32'd0 || iss_rd !== 5'd0 || iss_payload !== 64'h6) begin errors++;
      $display("FAIL zero_issue: v=%b op1=%h rd=%0d pl=%h want 1/0/0/6", iss_valid, iss_op1, iss_rd, iss_payload); end
    checks++; if (dut.u_busy.busy_q[0] !== 1'b0 || dut.u_busy.busy_q[7] !== 1'b1) begin errors++;
      $display("FAIL zero_busy: b0=%b b7=%b want 0/1", dut.u_busy.busy_q[0], dut.u_busy.busy_q[7]); end
    wb_write(5'd7, 32'h77);
  endtask

  task automatic test_back_to_back();
    iss_ready = 1'b0;
    offer(5'd1, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 64'h8);
    offer(5'd2, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 64'h9);
    for (int i = 0; i < 3; i++) begin
      checks++; if (iss_valid !== 1'b1 || iss_op1 !== 32'd5 || iss_rd !== 5'd8 || iss_payload !== 64'h8) begin errors++;
        $display("FAIL bp_iss_stable[%0d]: v=%b op1=%h rd=%0d pl=%h want 1/5/8/8", i, iss_valid, iss_op1, iss_rd, iss_payload); end
      checks++; if (dec_ready !== 1'b0 || raddr1 !== 5'd2) begin errors++;
        $display("FAIL bp_hold_stall[%0d]: dec_ready=%b raddr1=%0d want 0/2", i, dec_ready, raddr1); end
      clk1();
    end
    iss_ready = 1'b1;
    #1;
    checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL bp_release: dec_ready=%b want 1", dec_ready); end
    clk1();
    checks++; if (iss_valid !== 1'b1 || iss_op1 !== 32'd7 || iss_rd !== 5'd9 || iss_payload !== 64'h9) begin errors++;
      $display("FAIL bp_second: v=%b op1=%h rd=%0d pl=%h want 1/7/9/9", iss_valid, iss_op1, iss_rd, iss_payload); end
    clk1();
    checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: iss_valid=%b want 0", iss_valid); end
    wb_write(5'd8, 32'h88);
    wb_write(5'd9, 32'h99);
  endtask

  task automatic test_flush_reset();
    offer(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 64'hA);
    offer(5'd5, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 64'hB);
    checks++; if (dec_ready !== 1'b0) begin errors++; $display("FAIL flush_pre_stall: dec_ready=%b want 0", dec_ready); end
    flush = 1'b1; wb_valid = 1'b1; wb_rd = 5'd12; wb_data = 32'h1212;
    #1;
    checks++; if (dec_ready !== 1'b0 || we !== 1'b1 || waddr !== 5'd12) begin errors++;
      $display("FAIL flush_cycle: dec_ready=%b we=%b waddr=%0d want 0/1/12", dec_ready, we, waddr); end
    clk1();
    flush = 1'b0; wb_valid = 1'b0;
    checks++; if (dut.hold_valid !== 1'b0 || iss_valid !== 1'b0 || dut.u_busy.busy_q !== 32'd0) begin errors++;
      $display("FAIL flush_clear: hold=%b iss=%b busy=%h want 0/0/0", dut.hold_valid, iss_valid, dut.u_busy.busy_q); end
    checks++; if (rf[12] !== 32'h1212) begin errors++; $display("FAIL flush_wb_written: x12=%h want 1212", rf[12]); end
    iss_ready = 1'b0;
    offer(5'd1, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 64'hC);
    clk1();
    checks++; if (iss_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_issue: iss_valid=%b want 1", iss_valid); end
    rst_in = 1'b0;
    #1;
    checks++; if (iss_valid !== 1'b0 || iss_payload !== 64'd0 || dut.hold_valid !== 1'b0 || dut.u_busy.busy_q !== 32'd0) begin errors++;
      $display("FAIL rst_async: iss=%b pl=%h hold=%b busy=%h want all 0", iss_valid, iss_payload, dut.hold_valid, dut.u_busy.busy_q); end
    #2;
    rst_in = 1'b1;
    iss_ready = 1'b1;
    clk1();
    checks++; if (dec_ready !== 1'b1 || iss_valid !== 1'b0) begin errors++;
      $display("FAIL rst_release: dec_ready=%b iss_valid=%b want 1/0", dec_ready, iss_valid); end
  endtask

  initial begin
    rst_in = 1'b0; flush = 1'b0; dec_valid = 1'b0;
    dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0;
    dec_rs1_en = 1'b0; dec_rs2_en = 1'b0; dec_rd_en = 1'b0; dec_payload = '0;
    wb_valid = 1'b0; wb_rd = '0; wb_data = '0; iss_ready = 1'b1;
    test_reset();
    wb_write(5'd1, 32'd5);
    wb_write(5'd2, 32'd7);
    test_single();
    test_raw();
    test_waw();
    test_zero_reg();
    clk1();
    test_back_to_back();
    test_flush_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Operand-fetch stage between instruction decode and execute in the RISC-V core.
- Drives the two read ports of `regfile` and owns a busy-bit scoreboard that stalls on RAW/WAW hazards.
- Forwards writeback onto the regfile write port.
- Two-entry pipeline: a hold slot for the decoded instruction, then an output slot with the fetched operands. Sustains 1 instr/cycle.

Parameters:
XLEN, 32, data width (matches `RegBus`)
REG_NUM, 32, architectural register count
REG_ADDR_W, 5, register index width (log2 REG_NUM)
PAYLOAD_W, 64, opaque decode payload (pc, imm, opcode) carried through unchanged

Ports:
clk_in  in  1  clock, rising edge
rst_in  in  1  asynchronous reset, active-low
flush  in  1  synchronous squash from branch resolution
dec_valid  in  1  decode offers instruction
dec_ready  out  1  block accepts instruction
dec_rs1/dec_rs2  in  REG_ADDR_W  source indices
dec_rs1_en/dec_rs2_en  in  1  source used
dec_rd  in  REG_ADDR_W  destination index
dec_rd_en  in  1  destination written
dec_payload  in  PAYLOAD_W  passthrough
re1/re2  out  1  regfile read enables
raddr1/raddr2  out  REG_ADDR_W  regfile read addresses
rdata1/rdata2  in  XLEN  regfile read data (same-cycle write bypass done in regfile)
we  out  1  regfile write enable
waddr  out  REG_ADDR_W  regfile write address
wdata  out  XLEN  regfile write data
wb_valid  in  1  writeback this cycle
wb_rd  in  REG_ADDR_W  writeback index
wb_data  in  XLEN  writeback data
iss_valid  out  1  operands ready for execute
iss_ready  in  1  execute accepts
iss_op1/iss_op2  out  XLEN  operand values (0 when source unused)
iss_rd  out  REG_ADDR_W  destination
iss_rd_en  out  1  destination written
iss_payload  out  PAYLOAD_W  passthrough

Behaviour:
- Reset (rst_in=0, async): hold_valid=0, iss_valid=0, iss_op1/op2/rd/payload=0, iss_rd_en=0, busy[]=0. After release dec_ready=1.
- Writeback path is combinational: we=wb_valid, waddr=wb_rd, wdata=wb_data. It is never gated by flush.
- Read ports are combinational from the hold slot:
  - re1=hold_valid&rs1_en, raddr1=hold_rs1.
  - re2 and raddr2 likewise from rs2.
- wb_clr(r) = wb_valid & wb_rd==r.
- Hazard terms:
  - haz1 = rs1_en & rs1!=0 & busy[rs1] & !wb_clr(rs1)
  - haz2 is the same form on rs2.
  - haz_waw = rd_en & rd!=0 & busy[rd] & !wb_clr(rd)
- out_free = !iss_valid | iss_ready.
- advance = hold_valid & !(haz1|haz2|haz_waw) & out_free & !flush.
- On advance:
  - Output slot captures rdata1/rdata2, or 0 when the source is disabled, plus rd, rd_en and payload.
  - iss_valid<=1.
  - If rd_en & rd!=0, busy[rd]<=1.
- Otherwise, if iss_ready, iss_valid<=0.
- dec_ready = !flush & (!hold_valid | advance). Accept loads the hold slot at the edge.
- Minimum latency: accepted at edge N, iss_valid high after edge N+1.
- Busy bookkeeping, per edge:
  - wb_valid & wb_rd!=0 clears busy[wb_rd].
  - An advance setting the same index in the same cycle wins; the bit stays 1.
  - busy[0] is constant 0.
- Back-to-back dependency: the dependent instruction sees the busy bit the cycle after its producer advances. It stalls until that producer's writeback cycle, then advances using the regfile bypass value.
- Stall holds the hold slot and all read addresses stable. iss_* are stable while iss_valid & !iss_ready.
- flush (sync, priority over all but reset):
  - Clears hold_valid, iss_valid and all busy bits.
  - dec_ready=0 that cycle.
  - The wb in that cycle still writes the regfile.
  - The system guarantees no older writer is in flight when flush asserts.
- Reset mid-stall or mid-issue: everything drops immediately (async). In-flight instructions are lost.

Decomposition:
- `defines.v` holds `RegBus`, `RegAddrBus`, `RegNum`, `RegNumLog2`, `ZeroWord`, `ReadEnable`, `WriteEnable`.
- Add `RstEnableN` (1'b0) to `defines.v` for the active-low reset level.
- One sub-module, reg_busy_table, holds the REG_NUM-bit busy vector:
  - set port and clear port
  - flush clear
  - three combinational lookups with clear-bypass

Test Plan:
- Reset then one instr rs1=1, rs2=2, rd=3, regs x1=5, x2=7 -> iss_valid one cycle after accept, op1=5, op2=7, busy[3]=1.
- RAW: issue rd=3, then rs1=3; wb x3=0x11 four cycles later -> second instr stalls, advances in the wb cycle with op1=0x11, dec_ready low during stall.
- WAW plus simultaneous wb of rd=4 and advance of another rd=4 writer -> busy[4] remains 1 after the edge.
- rs1=0, rd=0 with busy set elsewhere -> no stall, op1=0, busy[0] stays 0.
- iss_ready low for 3 cycles with two instrs queued -> iss_* stable, hold slot stalls, dec_ready=0, no data loss when released.
- flush while stalled on busy[5], then reset asserted mid-issue -> hold/iss cleared, busy all 0; after async reset iss_valid=0 immediately.
